// File: rtl/datapath.sv
// Accumulator datapath: PC, IR, A and a 32x8 unified program/data memory.
// Optional sticky signed-overflow flag is enabled by defining DATAPATH_OVF_EN.
module datapath #(
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       IRload,
  input  logic       JMPmux,
  input  logic       PCload,
  input  logic       Meminst,
  input  logic       MemWr,
  input  logic [1:0] Asel,
  input  logic       Aload,
  input  logic       Sub,
  input  logic [7:0] Input,
  input  logic       LoadEn,
  input  logic [4:0] LoadAddr,
  input  logic [7:0] LoadData,
  output logic [7:0] IR,
  output logic       Aeq0,
  output logic       Apos,
  output logic [7:0] Output,
  output logic [4:0] PC,
  output logic       Ovf
);

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

  logic [7:0] mem [MEM_DEPTH];
  logic [4:0] addr;
  logic [7:0] m;
  logic [7:0] opnd;
  logic [7:0] sum;
  logic [7:0] a_next;
  logic [4:0] pc_next;
  logic [7:0] a_q;
  logic [7:0] ir_q;
  logic [4:0] pc_q;

  assign addr = Meminst ? ir_q[4:0] : pc_q;
  assign m    = mem[addr];

  always_comb begin
    opnd    = Sub ? ~m : m;
    sum     = a_q + opnd + {7'b0, Sub};
    pc_next = JMPmux ? ir_q[4:0] : pc_q + 5'd1;
    a_next  = '0;
    case (Asel)
      ASEL_ALU:  a_next = sum;
      ASEL_IN:   a_next = Input;
      ASEL_MEM:  a_next = m;
      ASEL_ZERO: a_next = '0;
      default:   a_next = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else begin
      if (IRload) ir_q <= m;
      if (PCload) pc_q <= pc_next;
      if (Aload)  a_q  <= a_next;
    end
  end

  // Memory is not reset; writes on an edge while Reset is low are dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (LoadEn)
        mem[LoadAddr] <= LoadData;
      else if (MemWr)
        mem[addr] <= a_q;
    end
  end

`ifdef DATAPATH_OVF_EN
  logic ovf_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      ovf_q <= 1'b0;
    else if (Aload && (Asel == ASEL_ALU) && (a_q[7] == opnd[7]) && (sum[7] != a_q[7]))
      ovf_q <= 1'b1;
  end

  assign Ovf = ovf_q;
`else
  assign Ovf = 1'b0;
`endif

  assign IR     = ir_q;
  assign PC     = pc_q;
  assign Output = a_q;
  assign Aeq0   = (a_q == '0);
  assign Apos   = !a_q[7] && (a_q != '0);

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus pushes expected register/flag values,
// a monitor process pops and compares them against the DUT.
module tb_datapath;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, LoadEn;
  logic [1:0] Asel;
  logic [7:0] Input, LoadData;
  logic [4:0] LoadAddr;
  logic [7:0] IR, Output;
  logic [4:0] PC;
  logic       Aeq0, Apos, Ovf;

  always #5 Clock = ~Clock;

  datapath #(.MEM_DEPTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel),
    .Aload(Aload), .Sub(Sub), .Input(Input), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .IR(IR), .Aeq0(Aeq0),
    .Apos(Apos), .Output(Output), .PC(PC), .Ovf(Ovf)
  );

`ifdef DATAPATH_OVF_EN
  localparam logic [7:0] OVF_EXP = 8'h01;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  typedef enum int {S_PC, S_IR, S_OUT, S_AEQ, S_APOS, S_OVF} sig_e;
  typedef struct {
    string      name;
    sig_e       sig;
    logic [7:0] exp;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] cur_ir;
  exp_t       e;
  logic [7:0] act;

  function automatic logic [7:0] sample(sig_e s);
    case (s)
      S_PC:    return {3'b000, PC};
      S_IR:    return IR;
      S_OUT:   return Output;
      S_AEQ:   return {7'b0, Aeq0};
      S_APOS:  return {7'b0, Apos};
      default: return {7'b0, Ovf};
    endcase
  endfunction

  // Monitor: compares every queued expectation as soon as it is presented.
  initial begin
    forever begin
      wait (q.size() != 0);
      e   = q.pop_front();
      act = sample(e.sig);
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string n, input sig_e s, input logic [7:0] v);
    exp_t t;
    t.name = n;
    t.sig  = s;
    t.exp  = v;
    q.push_back(t);
  endtask

  task automatic idle();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Aload = 0; Sub = 0; LoadEn = 0; Asel = 2'b00;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    LoadEn = 1; LoadAddr = a; LoadData = d;
    step();
    LoadEn = 0;
  endtask

  task automatic fetch();
    IRload = 1; PCload = 1; JMPmux = 0; Meminst = 0;
    step();
    idle();
  endtask

  // Places x at mem[IR[4:0]] and loads it into IR through the operand path.
  task automatic set_ir(input logic [7:0] x);
    load(cur_ir[4:0], x);
    Meminst = 1; IRload = 1;
    step();
    idle();
    cur_ir = x;
    expect_v("set_ir", S_IR, x);
  endtask

  task automatic a_op(input logic [1:0] sel, input logic sub_op, input logic meminst);
    Aload = 1; Asel = sel; Sub = sub_op; Meminst = meminst;
    step();
    idle();
  endtask

  initial begin
    Reset = 0; idle(); Input = '0; LoadAddr = '0; LoadData = '0; cur_ir = '0;
    #3;
    expect_v("rst_pc", S_PC, 8'h00);
    expect_v("rst_ir", S_IR, 8'h00);
    expect_v("rst_out", S_OUT, 8'h00);
    expect_v("rst_aeq0", S_AEQ, 8'h01);
    expect_v("rst_apos", S_APOS, 8'h00);
    expect_v("rst_ovf", S_OVF, 8'h00);
    @(negedge Clock) Reset = 1;

    load(5'd0, 8'h45); load(5'd1, 8'h1F); load(5'd31, 8'hE9);
    load(5'd5, 8'h10); load(5'd6, 8'h03); load(5'd7, 8'h20); load(5'd10, 8'h01);

    fetch(); cur_ir = 8'h45;
    expect_v("fetch_ir", S_IR, 8'h45);
    expect_v("fetch_pc", S_PC, 8'h01);
    fetch(); cur_ir = 8'h1F;
    JMPmux = 1; PCload = 1; step(); idle();
    expect_v("jmp_pc31", S_PC, 8'h1F);
    fetch(); cur_ir = 8'hE9;
    expect_v("wrap_ir", S_IR, 8'hE9);
    expect_v("wrap_pc", S_PC, 8'h00);

    load(5'd0, 8'hB4);
    fetch(); cur_ir = 8'hB4;
    JMPmux = 1; PCload = 0; step(); idle();
    expect_v("jmp_hold_pc", S_PC, 8'h01);
    JMPmux = 1; PCload = 1; step(); idle();
    expect_v("jmp_pc", S_PC, 8'h14);

    set_ir(8'h05);
    a_op(2'b10, 0, 1);
    expect_v("lda", S_OUT, 8'h10);
    set_ir(8'h06);
    a_op(2'b00, 0, 1);
    expect_v("add", S_OUT, 8'h13);
    a_op(2'b00, 1, 1);
    expect_v("sub", S_OUT, 8'h10);
    set_ir(8'h07);
    a_op(2'b00, 1, 1);
    expect_v("sub_neg", S_OUT, 8'hF0);
    expect_v("neg_apos", S_APOS, 8'h00);
    expect_v("neg_aeq0", S_AEQ, 8'h00);
    expect_v("no_ovf", S_OVF, 8'h00);
    a_op(2'b11, 0, 0);
    expect_v("zero_out", S_OUT, 8'h00);
    expect_v("zero_aeq0", S_AEQ, 8'h01);

    Input = 8'h7F;
    a_op(2'b01, 0, 0);
    expect_v("in_out", S_OUT, 8'h7F);
    expect_v("in_apos", S_APOS, 8'h01);
    set_ir(8'h09);
    MemWr = 1; Meminst = 1; step(); idle();
    a_op(2'b11, 0, 0);
    a_op(2'b10, 0, 1);
    expect_v("store_rd", S_OUT, 8'h7F);
    MemWr = 1; Meminst = 1; LoadEn = 1; LoadAddr = 5'd9; LoadData = 8'h22;
    step(); idle();
    a_op(2'b10, 0, 1);
    expect_v("loaden_prio", S_OUT, 8'h22);
    Input = 8'h55;
    Aload = 1; Asel = 2'b01; MemWr = 1; Meminst = 1; step(); idle();
    expect_v("ld_st_a", S_OUT, 8'h55);
    a_op(2'b10, 0, 1);
    expect_v("ld_st_mem", S_OUT, 8'h22);

    Input = 8'h7F;
    a_op(2'b01, 0, 0);
    set_ir(8'h0A);
    a_op(2'b00, 0, 1);
    expect_v("ovf_out", S_OUT, 8'h80);
    expect_v("h80_aeq0", S_AEQ, 8'h00);
    expect_v("h80_apos", S_APOS, 8'h00);
    expect_v("ovf_set", S_OVF, OVF_EXP);
    Input = 8'h00;
    a_op(2'b01, 0, 0);
    expect_v("ovf_sticky", S_OVF, OVF_EXP);
    expect_v("in0_aeq0", S_AEQ, 8'h01);
    Input = 8'h33;
    a_op(2'b01, 0, 0);

    #2 Reset = 0;
    #1;
    expect_v("mid_rst_pc", S_PC, 8'h00);
    expect_v("mid_rst_ir", S_IR, 8'h00);
    expect_v("mid_rst_out", S_OUT, 8'h00);
    expect_v("mid_rst_aeq0", S_AEQ, 8'h01);
    expect_v("mid_rst_ovf", S_OVF, 8'h00);
    LoadEn = 1; LoadAddr = 5'd0; LoadData = 8'h77; MemWr = 1; IRload = 1; PCload = 1;
    step(); idle();
    expect_v("rst_hold_pc", S_PC, 8'h00);
    @(negedge Clock) Reset = 1;
    fetch();
    expect_v("rst_nowr_ir", S_IR, 8'hB4);
    expect_v("rst_nowr_pc", S_PC, 8'h01);

    repeat (2) @(posedge Clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath.md
# datapath

8-bit accumulator datapath for the 3-bit-opcode / 5-bit-address processor. It holds the program counter (PC), instruction register (IR), accumulator (A) and a 32×8 unified program/data memory. It executes the register transfers requested each cycle by the control unit's strobes, and returns the opcode field and the A status flags that the control unit branches on. It is the direct consumer of every control-unit output.

## Interface
Parameters:
- `MEM_DEPTH`, default 32: memory words. Fixed to 2^5, matching the 5-bit address field.

Ports:
- `Clock` in 1: single clock, rising-edge.
- `Reset` in 1: asynchronous, active-low reset.
- `IRload` in 1: load IR from memory read data.
- `JMPmux` in 1: PC next-value select. 0 = PC+1, 1 = IR[4:0].
- `PCload` in 1: load PC with the JMPmux selection.
- `Meminst` in 1: memory address select. 0 = PC, 1 = IR[4:0].
- `MemWr` in 1: write A to memory at the selected address.
- `Asel` in 2: A input select. 00 = add/sub result, 01 = `Input`, 10 = memory read data, 11 = 8'h00.
- `Aload` in 1: load A from the Asel selection.
- `Sub` in 1: arithmetic unit op. 0 = A + M, 1 = A − M.
- `Input` in 8: external switch value.
- `LoadEn` in 1: program-load write strobe.
- `LoadAddr` in 5: program-load address.
- `LoadData` in 8: program-load data.
- `IR` out 8: instruction register. Bits [7:5] go to the control unit.
- `Aeq0` out 1: A == 0.
- `Apos` out 1: A is nonzero with A[7] == 0, i.e. strictly positive in two's complement.
- `Output` out 8: A register value.
- `PC` out 5: program counter.
- `Ovf` out 1: sticky signed overflow flag (see Configuration).

## Operation
- Memory address: `Meminst` ? IR[4:0] : PC.
- Memory read is asynchronous. M = mem[address], combinational from the address.
- Arithmetic unit:
  - Result = A + M, or A + ~M + 1 when `Sub` = 1.
  - 8-bit modular; carry out is discarded.
- Registers update on the rising edge of `Clock`, each only under its own strobe:
  - IR ← M when `IRload`.
  - PC ← (`JMPmux` ? IR[4:0] : PC+1) when `PCload`. PC+1 wraps 31 → 0.
  - A ← Asel mux output when `Aload`.
- Memory write:
  - mem[address] ← A on a rising edge with `MemWr` = 1 and `LoadEn` = 0.
  - mem[`LoadAddr`] ← `LoadData` on a rising edge with `LoadEn` = 1. `LoadEn` takes priority and the `MemWr` write that cycle is dropped.
- Simultaneous `IRload` and `PCload`, as in a fetch cycle: IR captures mem[old PC] and PC becomes old PC+1.
- Simultaneous `Aload` and `MemWr`: memory receives the pre-edge A value.
- Flags `Aeq0` and `Apos` are combinational from the A register, never from the mux.
- A = 8'h80 gives `Aeq0` = 0 and `Apos` = 0.

## Timing
- `Reset` low: PC = 0, IR = 8'h00, A = 8'h00, `Ovf` = 0. This happens immediately and independent of `Clock`. Consequently `Output` = 0, `Aeq0` = 1, `Apos` = 0.
- Memory contents are not affected by reset.
- Reset asserted mid-instruction aborts it. A `MemWr` or `LoadEn` on the same edge while `Reset` is low is suppressed.
- Release of `Reset` is sampled synchronously; the first register update occurs on the first rising edge with `Reset` high.
- Latency: every strobe takes effect at the next rising edge. Memory read data is valid in the same cycle as the address change, so a `Meminst` = 1 decode cycle followed by the load/add cycle needs no extra wait.
- There is no handshake: strobes are trusted to be stable before the edge.

## Configuration
- `DATAPATH_OVF_EN` defined:
  - On any edge with `Aload` = 1 and `Asel` = 00, `Ovf` is set if the operands have equal effective sign and the result sign differs. The effective second operand is ~M when `Sub` = 1.
  - `Ovf` is sticky until `Reset`.
  - Loads through `Input` or memory never alter it.
- `DATAPATH_OVF_EN` undefined: no overflow logic; `Ovf` is tied to 0.

## Test plan
- Reset: hold `Reset` = 0 mid-clock after arbitrary state -> PC = 0, IR = 0, `Output` = 0, `Aeq0` = 1 immediately, without a clock edge.
- Fetch: preload mem[0] = 8'h45 via `LoadEn`, then one edge with `IRload` = `PCload` = 1 -> IR = 8'h45, PC = 1. Repeat from PC = 31 -> PC wraps to 0.
- Load/add/sub: mem[5] = 8'h10, mem[6] = 8'h03; `Aload` with `Asel` = 10 at addr 5 -> A = 8'h10; add at addr 6 -> 8'h13; sub at addr 6 with `Sub` = 1 -> 8'h10. Then A = 8'h10 minus M = 8'h20 -> 8'hF0, `Apos` = 0, `Aeq0` = 0.
- Store and input: `Input` = 8'h7F with `Asel` = 01 and `Aload` -> A = 8'h7F, `Apos` = 1. `MemWr` with IR[4:0] = 9 -> mem[9] = 8'h7F. Same edge with `LoadEn` = 1 at addr 9 with data 8'h22 -> mem[9] = 8'h22.
- Jump: IR = 8'hB4 with `JMPmux` = 1 and `PCload` = 1 -> PC = 5'h14. The same strobes with `PCload` = 0 -> PC unchanged.
- Overflow (macro on): A = 8'h7F plus M = 8'h01 -> A = 8'h80, `Ovf` = 1. `Ovf` stays 1 after a following `Input` load of 0. With the macro off, the same stimulus gives `Ovf` = 0.
